// File: rtl/ysyx_23060075_gpr_ctrl_pkg.sv
// Shared widths and requester IDs for the GPR write-side controller.
package ysyx_23060075_gpr_ctrl_pkg;
    localparam int ysyx_23060075_REG_ADDR_WIDTH = 5;
    localparam int ysyx_23060075_ISA_WIDTH      = 32;

    // Requester IDs double as bit positions in the arbiter req/gnt vectors.
    localparam logic REQ_EXU = 1'b0;
    localparam logic REQ_LSU = 1'b1;
endpackage

// File: rtl/ysyx_23060075_rr_arb2.sv
// Two-way round-robin arbiter; on contention the requester not granted last wins.
module ysyx_23060075_rr_arb2
    import ysyx_23060075_gpr_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last;

    // Reset value marks LSU as last served so EXU wins the first contention.
    always_comb begin
        gnt = 2'b00;
        gnt[REQ_EXU] = req[REQ_EXU] && (!req[REQ_LSU] || last == REQ_LSU);
        gnt[REQ_LSU] = req[REQ_LSU] && (!req[REQ_EXU] || last == REQ_EXU);
    end

    always_ff @(posedge clk) begin
        if (rst)
            last <= REQ_LSU;
        else if (|gnt)
            last <= gnt[REQ_LSU] ? REQ_LSU : REQ_EXU;
    end
endmodule

// File: rtl/ysyx_23060075_gpr_ctrl.sv
// GPR write-port controller: arbitrates EXU/LSU writebacks, registers the write,
// and keeps a busy scoreboard that stalls issue on RAW/WAW hazards.
module ysyx_23060075_gpr_ctrl
    import ysyx_23060075_gpr_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = ysyx_23060075_REG_ADDR_WIDTH,
    parameter int DATA_WIDTH = ysyx_23060075_ISA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic [ADDR_WIDTH-1:0] issue_rs1,
    input  logic [ADDR_WIDTH-1:0] issue_rs2,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic                  issue_rd_en,
    input  logic                  exu_wb_valid,
    output logic                  exu_wb_ready,
    input  logic [ADDR_WIDTH-1:0] exu_wb_addr,
    input  logic [DATA_WIDTH-1:0] exu_wb_data,
    input  logic                  lsu_wb_valid,
    output logic                  lsu_wb_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_wb_addr,
    input  logic [DATA_WIDTH-1:0] lsu_wb_data,
    output logic [DATA_WIDTH-1:0] gpr_w,
    output logic [ADDR_WIDTH-1:0] gpr_w_addr,
    output logic                  gpr_w_en,
    output logic                  wb_err
);
    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0]       busy, busy_next;
    logic [1:0]            req, gnt;
    logic                  wb_accept, issue_set;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;

    assign req = {lsu_wb_valid, exu_wb_valid};

    ysyx_23060075_rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign exu_wb_ready = gnt[REQ_EXU];
    assign lsu_wb_ready = gnt[REQ_LSU];
    assign wb_accept    = |gnt;
    assign wb_addr      = gnt[REQ_LSU] ? lsu_wb_addr : exu_wb_addr;
    assign wb_data      = gnt[REQ_LSU] ? lsu_wb_data : exu_wb_data;

    assign issue_ready = !busy[issue_rs1] && !busy[issue_rs2] &&
                         !(issue_rd_en && busy[issue_rd]);
    assign issue_set   = issue_valid && issue_ready && issue_rd_en && (issue_rd != '0);

    // Set and clear never hit the same register: issue stalls while rd is busy.
    always_comb begin
        busy_next = busy;
        if (gpr_w_en)
            busy_next[gpr_w_addr] = 1'b0;
        if (issue_set)
            busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            gpr_w_en   <= 1'b0;
            gpr_w      <= '0;
            gpr_w_addr <= '0;
            wb_err     <= 1'b0;
        end else begin
            busy     <= busy_next;
            gpr_w_en <= wb_accept && (wb_addr != '0);
            if (wb_accept) begin
                gpr_w      <= wb_data;
                gpr_w_addr <= wb_addr;
            end
            if (wb_accept && (wb_addr != '0) && !busy[wb_addr])
                wb_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ysyx_23060075_gpr_ctrl.sv
// Scoreboard bench: stimulus pushes expected GPR writes, a monitor pops and checks them.
module tb_ysyx_23060075_gpr_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_ready, issue_rd_en;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd;
    logic        exu_wb_valid, exu_wb_ready, lsu_wb_valid, lsu_wb_ready;
    logic [4:0]  exu_wb_addr, lsu_wb_addr, gpr_w_addr;
    logic [31:0] exu_wb_data, lsu_wb_data, gpr_w;
    logic        gpr_w_en, wb_err;

    int n_chk = 0;
    int n_fail = 0;
    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    ysyx_23060075_gpr_ctrl dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_rd_en(issue_rd_en),
        .exu_wb_valid(exu_wb_valid), .exu_wb_ready(exu_wb_ready),
        .exu_wb_addr(exu_wb_addr), .exu_wb_data(exu_wb_data),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
        .lsu_wb_addr(lsu_wb_addr), .lsu_wb_data(lsu_wb_data),
        .gpr_w(gpr_w), .gpr_w_addr(gpr_w_addr), .gpr_w_en(gpr_w_en),
        .wb_err(wb_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every registered write must match the oldest expected write.
    always @(negedge clk) begin
        if (gpr_w_en === 1'b1) begin
            logic [36:0] e;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected none", gpr_w_addr, gpr_w);
            end else begin
                e = exp_q.pop_front();
                chk("w_addr", {27'd0, gpr_w_addr}, {27'd0, e[36:32]});
                chk("w_data", gpr_w, e[31:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rd_en, input logic vld);
        issue_rs1 = rs1; issue_rs2 = rs2; issue_rd = rd;
        issue_rd_en = rd_en; issue_valid = vld;
    endtask

    task automatic exu(input logic v, input logic [4:0] a, input logic [31:0] d);
        exu_wb_valid = v; exu_wb_addr = a; exu_wb_data = d;
    endtask

    task automatic lsu(input logic v, input logic [4:0] a, input logic [31:0] d);
        lsu_wb_valid = v; lsu_wb_addr = a; lsu_wb_data = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        probe(0, 0, 0, 0, 0);
        exu(0, 0, 0);
        lsu(0, 0, 0);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        chk("rst_w_en", {31'd0, gpr_w_en}, 32'd0);
        chk("rst_w_addr", {27'd0, gpr_w_addr}, 32'd0);
        chk("rst_wb_err", {31'd0, wb_err}, 32'd0);
        chk("rst_ready", {31'd0, issue_ready}, 32'd1);

        // Basic writeback to x5
        step();
        probe(0, 0, 5, 1, 1);
        @(negedge clk); chk("basic_issue_ready", {31'd0, issue_ready}, 32'd1);
        step();
        probe(5, 0, 0, 0, 0);
        exu(1, 5, 32'hDEADBEEF);
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        @(negedge clk);
        chk("basic_exu_ready", {31'd0, exu_wb_ready}, 32'd1);
        chk("basic_busy5", {31'd0, issue_ready}, 32'd0);
        step();
        exu(0, 0, 0);
        @(negedge clk); chk("basic_busy5_write_cycle", {31'd0, issue_ready}, 32'd0);
        step();
        @(negedge clk); chk("basic_cleared", {31'd0, issue_ready}, 32'd1);

        // RAW / WAW on x7, written back by LSU
        step();
        probe(0, 0, 7, 1, 1);
        step();
        probe(7, 0, 0, 0, 1);
        @(negedge clk); chk("raw_stall", {31'd0, issue_ready}, 32'd0);
        step();
        probe(0, 0, 7, 1, 1);
        @(negedge clk); chk("waw_stall", {31'd0, issue_ready}, 32'd0);
        step();
        probe(7, 0, 0, 0, 0);
        lsu(1, 7, 32'h0000_0077);
        exp_q.push_back({5'd7, 32'h0000_0077});
        @(negedge clk);
        chk("raw_lsu_ready", {31'd0, lsu_wb_ready}, 32'd1);
        chk("raw_stall2", {31'd0, issue_ready}, 32'd0);
        step();
        lsu(0, 0, 0);
        @(negedge clk); chk("raw_stall_commit", {31'd0, issue_ready}, 32'd0);
        step();
        @(negedge clk); chk("raw_release", {31'd0, issue_ready}, 32'd1);

        // Contention right after reset: EXU, LSU, EXU, LSU
        do_reset();
        for (int r = 10; r <= 13; r++) begin
            probe(0, 0, 5'(r), 1, 1);
            step();
        end
        probe(0, 0, 0, 0, 0);
        exu(1, 10, 32'hA10); lsu(1, 11, 32'hA11);
        exp_q.push_back({5'd10, 32'hA10});
        @(negedge clk);
        chk("cont1_exu", {31'd0, exu_wb_ready}, 32'd1);
        chk("cont1_lsu", {31'd0, lsu_wb_ready}, 32'd0);
        step();
        exu(1, 12, 32'hA12);
        exp_q.push_back({5'd11, 32'hA11});
        @(negedge clk);
        chk("cont2_lsu", {31'd0, lsu_wb_ready}, 32'd1);
        chk("cont2_exu", {31'd0, exu_wb_ready}, 32'd0);
        step();
        lsu(1, 13, 32'hA13);
        exp_q.push_back({5'd12, 32'hA12});
        @(negedge clk); chk("cont3_exu", {31'd0, exu_wb_ready}, 32'd1);
        step();
        exu(1, 14, 32'hA14);
        exp_q.push_back({5'd13, 32'hA13});
        @(negedge clk);
        chk("cont4_lsu", {31'd0, lsu_wb_ready}, 32'd1);
        chk("cont4_exu", {31'd0, exu_wb_ready}, 32'd0);
        step();
        exu(0, 0, 0); lsu(0, 0, 0);
        step();
        @(negedge clk); chk("cont_no_err", {31'd0, wb_err}, 32'd0);

        // x0: issue rd=0, LSU wb to x0 is accepted and dropped
        step();
        probe(0, 0, 0, 1, 1);
        step();
        probe(0, 0, 0, 1, 0);
        lsu(1, 0, 32'h1234);
        @(negedge clk); chk("x0_lsu_ready", {31'd0, lsu_wb_ready}, 32'd1);
        step();
        lsu(0, 0, 0);
        @(negedge clk);
        chk("x0_no_write", {31'd0, gpr_w_en}, 32'd0);
        chk("x0_no_err", {31'd0, wb_err}, 32'd0);
        chk("x0_not_busy", {31'd0, issue_ready}, 32'd1);

        // Spurious writeback to x9
        step();
        exu(1, 9, 32'h99);
        exp_q.push_back({5'd9, 32'h99});
        @(negedge clk);
        chk("spur_ready", {31'd0, exu_wb_ready}, 32'd1);
        chk("spur_err_before", {31'd0, wb_err}, 32'd0);
        step();
        exu(0, 0, 0);
        @(negedge clk); chk("spur_err_set", {31'd0, wb_err}, 32'd1);
        step(); step();
        @(negedge clk); chk("spur_err_hold", {31'd0, wb_err}, 32'd1);

        // Reset in the write cycle of an accepted x3 writeback
        step();
        probe(0, 0, 3, 1, 1);
        step();
        probe(0, 0, 4, 1, 1);
        step();
        probe(3, 4, 0, 0, 0);
        exu(1, 3, 32'h33);
        exp_q.push_back({5'd3, 32'h33});
        @(negedge clk);
        chk("mid_exu_ready", {31'd0, exu_wb_ready}, 32'd1);
        chk("mid_busy34", {31'd0, issue_ready}, 32'd0);
        step();
        exu(0, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_w_en", {31'd0, gpr_w_en}, 32'd0);
        chk("mid_err_clr", {31'd0, wb_err}, 32'd0);
        chk("mid_ready", {31'd0, issue_ready}, 32'd1);

        step(); step();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
